// File: rtl/sequential_alu.sv
`default_nettype none
// ============================================================================
// Module   : sequential_alu
// Purpose  : Multicycle ALU. AND/OR/NOR/ADD/SUB/LUI complete in one EXEC
//            cycle; SLL/SRL shift one bit per cycle. A registered Done pulse
//            marks completion, with ALUResult, Zero and Error.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-low reset
//            Start        - request, sampled only while Busy=0
//            ALUOperation - 4-bit decoded op code (1000..1111 illegal)
//            Shamt        - 1: amount from ShiftAmount, 0: from A[SHAMT_BITS-1:0]
//            A, B         - operands (B is the shifted operand)
//            ShiftAmount  - instruction shamt field
//            Busy         - operation in progress
//            Done         - one-cycle completion pulse
//            ALUResult    - registered result, held until next completion
//            Zero         - ALUResult == 0, registered with ALUResult
//            Error        - illegal op code, pulses with Done
// Revision : 1.0 - initial release
// ============================================================================
module sequential_alu #(
  parameter int N_BITS     = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [3:0]            ALUOperation,
  input  logic                  Shamt,
  input  logic [N_BITS-1:0]     A,
  input  logic [N_BITS-1:0]     B,
  input  logic [SHAMT_BITS-1:0] ShiftAmount,
  output logic                  Busy,
  output logic                  Done,
  output logic [N_BITS-1:0]     ALUResult,
  output logic                  Zero,
  output logic                  Error
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            op_q;
  logic [N_BITS-1:0]     a_q;
  logic [N_BITS-1:0]     b_q;      // operand B; doubles as shift working register
  logic [SHAMT_BITS-1:0] count_q;

  logic                  start_shift;
  logic [SHAMT_BITS-1:0] shift_amount;
  logic [N_BITS-1:0]     exec_result;
  logic                  exec_error;

  assign start_shift  = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);
  assign shift_amount = Shamt ? ShiftAmount : A[SHAMT_BITS-1:0];
  assign Busy         = (state_q != IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = start_shift ? SHIFT : EXEC;
      EXEC:    state_d = IDLE;
      SHIFT:   if (count_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle operations, evaluated from the latched operands
  always_comb begin
    exec_result = '0;
    exec_error  = 1'b0;
    case (op_q)
      OP_AND:  exec_result = a_q & b_q;
      OP_OR:   exec_result = a_q | b_q;
      OP_NOR:  exec_result = ~(a_q | b_q);
      OP_ADD:  exec_result = a_q + b_q;
      OP_SUB:  exec_result = a_q - b_q;
      OP_LUI:  exec_result = {b_q[15:0], {(N_BITS-16){1'b0}}};
      default: exec_error  = 1'b1;   // shift codes never reach EXEC
    endcase
  end

  // Operand latches, shift datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      count_q   <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Done  <= 1'b0;
      Error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            op_q    <= ALUOperation;
            a_q     <= A;
            b_q     <= B;
            count_q <= shift_amount;
          end
        end
        EXEC: begin
          ALUResult <= exec_result;
          Zero      <= (exec_result == '0);
          Error     <= exec_error;
          Done      <= 1'b1;
        end
        SHIFT: begin
          if (count_q != '0) begin
            b_q     <= (op_q == OP_SLL) ? (b_q << 1) : (b_q >> 1);
            count_q <= count_q - SHAMT_BITS'(1);
          end else begin
            ALUResult <= b_q;
            Zero      <= (b_q == '0);
            Done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sequential_alu.md
Name: sequential_alu

Overview:
- Multicycle ALU datapath unit that sits downstream of the ALU control decoder.
- Accepts a decoded 4-bit ALUOperation code and Shamt flag, plus operands, through a start/done handshake.
- Logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per cycle.
- Returns a registered result with Zero and Error flags to the multicycle processor datapath.

Parameters:
N_BITS, 32, datapath width of operands and result
SHAMT_BITS, 5, width of shift-amount field and iteration counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only when Busy=0
ALUOperation  input  4  decoded op: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 LUI, 0110 SLL, 0111 SRL; all other codes illegal
Shamt  input  1  1: shift amount from ShiftAmount; 0: shift amount from A[SHAMT_BITS-1:0]
A  input  N_BITS  operand A (rs)
B  input  N_BITS  operand B (rt/immediate); shifted operand for SLL/SRL
ShiftAmount  input  SHAMT_BITS  instruction shamt field
Busy  output  1  operation in progress
Done  output  1  one-cycle completion pulse
ALUResult  output  N_BITS  registered result; holds until next completion
Zero  output  1  ALUResult==0, registered with ALUResult
Error  output  1  illegal op code; pulses with Done

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; Busy, Done, Error, Zero = 0; ALUResult = 0; internal operand/counter registers = 0.
  - Reset mid-operation aborts it; no Done is produced.
- States: IDLE, EXEC, SHIFT.
- IDLE: at rising edge with Start=1, latch ALUOperation, A, B, and the selected shift amount into registers.
  - SLL/SRL -> SHIFT; counter = amount; working register = B.
  - Any other code -> EXEC.
  - Start=0 -> remain IDLE.
- Busy = 1 in EXEC and SHIFT, 0 in IDLE (combinational decode of state).
- Start while Busy=1 is ignored; inputs changing while Busy=1 have no effect.
- EXEC: one edge later, write ALUResult, Zero, Error; Done=1 for the following cycle; state -> IDLE.
  - Latency: Done high in the cycle after the edge following acceptance (one edge).
- SHIFT: each edge with counter != 0 shifts the working register by 1 and decrements counter.
  - SLL: left, zero fill. SRL: logical right, zero fill.
  - Edge with counter == 0: working register -> ALUResult, Done=1, state -> IDLE.
  - Shift by n completes n+1 edges after acceptance; n=0 takes 1 edge and returns B unchanged.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^N_BITS; no overflow or carry output.
  - SUB = A - B.
  - NOR = ~(A|B).
  - LUI = {B[15:0], 16'b0}; A ignored.
- Illegal code (1000 to 1111): completes via EXEC, ALUResult = 0, Zero = 1, Error = 1 for the Done cycle only.
- Done and Error are registered and high for exactly one cycle. Error is 0 for every legal op.
- Back-to-back: state is IDLE during the Done cycle, so a Start then is accepted. Next Done arrives no earlier than one cycle after.
- ALUResult and Zero change only at completion edges or reset.

Test Plan:
- Reset held low, then released; Start=0 for 5 cycles -> ALUResult=0, Busy=0, Done never asserts.
- ADD: A=7, B=5, Start one cycle -> Busy=1 one cycle; Done pulse with ALUResult=12, Zero=0, Error=0. Then SUB A=5, B=5, Start during the Done cycle -> next Done ALUResult=0, Zero=1.
- SUB A=3, B=5 -> ALUResult=0xFFFFFFFE. NOR A=0, B=0 -> 0xFFFFFFFF. LUI B=0x00001234 -> 0x12340000.
- SLL Shamt=1, ShiftAmount=31, B=1 -> Done exactly 32 edges after acceptance, ALUResult=0x80000000. Start pulsed and A/B changed mid-shift -> ignored, result unchanged.
- SRL Shamt=0, A=4, B=0x80000000 -> ALUResult=0x08000000 after 5 edges. SRL amount 0 -> B unchanged after 1 edge.
- Illegal op 1001 -> Done with Error=1, ALUResult=0, Zero=1. Reset asserted mid-SLL (amount 20, edge 10) -> outputs 0 immediately, no Done after release.
